// File: rtl/mux4_1_rr_arbiter_if.sv
// Request/data/grant bundle between the four mux requesters and the round-robin arbiter.
// The master side drives requests and data; the slave side (arbiter) returns grant and mux output.
interface mux4_1_rr_arbiter_if;
   logic [3:0] req_in;
   logic [3:0] data_in;
   logic [3:0] grant_out;
   logic [1:0] sel_out;
   logic       y_out;
   logic       valid_out;
   logic       busy_out;

   modport master (
      output req_in, data_in,
      input  grant_out, sel_out, y_out, valid_out, busy_out
   );

   modport slave (
      input  req_in, data_in,
      output grant_out, sel_out, y_out, valid_out, busy_out
   );
endinterface

// File: rtl/mux4_1_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with a per-grant hold limit
// and a registered data bit qualified by valid_out.
//
//   state | meaning
//   IDLE  | no grant active; outputs idle, y_out holds its last value
//   GRANT | one requester (sel_q) owns the mux; cnt_q counts held cycles
module mux4_1_rr_arbiter #(
   parameter int HOLD_MAX = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   mux4_1_rr_arbiter_if.slave bus
);

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_n;
   logic [3:0] grant_q, grant_n;
   logic [1:0] sel_q, sel_n;
   logic [1:0] ptr_q, ptr_n;
   logic [3:0] cnt_q, cnt_n;
   logic       y_q;
   logic       valid_q;
   logic [2:0] win_idle;
   logic [2:0] win_rel;
   logic [1:0] ptr_rel;

   // Returns {found, index}; the lowest offset from p with a set request wins.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
      logic [1:0] idx;
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign ptr_rel  = sel_q + 2'd1;
   assign win_idle = rr_pick(bus.req_in, ptr_q);
   assign win_rel  = rr_pick(bus.req_in, ptr_rel);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         grant_q <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
         y_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         sel_q   <= sel_n;
         ptr_q   <= ptr_n;
         cnt_q   <= cnt_n;
         valid_q <= |grant_q;
         if (|grant_q) y_q <= bus.data_in[sel_q];
      end
   end

   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      sel_n   = sel_q;
      ptr_n   = ptr_q;
      cnt_n   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (win_idle[2]) begin
               state_n = GRANT;
               grant_n = 4'b0001 << win_idle[1:0];
               sel_n   = win_idle[1:0];
               cnt_n   = 4'd1;
            end
         end
         GRANT: begin
            if (bus.req_in[sel_q] && (cnt_q < HOLD_LIM)) begin
               cnt_n = cnt_q + 4'd1;
            end else begin
               // Release re-arbitrates in the same cycle so hand-off has no bubble.
               ptr_n = ptr_rel;
               if (win_rel[2]) begin
                  grant_n = 4'b0001 << win_rel[1:0];
                  sel_n   = win_rel[1:0];
                  cnt_n   = 4'd1;
               end else begin
                  state_n = IDLE;
                  grant_n = 4'b0000;
                  cnt_n   = 4'd0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.grant_out = grant_q;
   assign bus.sel_out   = sel_q;
   assign bus.y_out     = y_q;
   assign bus.valid_out = valid_q;
   assign bus.busy_out  = |grant_q;

endmodule

// File: doc/mux4_1_rr_arbiter.md
# mux4_1_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit mux datapath. Four requesters compete for the mux. The block grants one requester at a time, drives the mux select from that grant, and registers the selected data bit with a valid flag. A per-grant hold limit prevents any requester from monopolising the mux. It sits directly in front of the `mux4_1` select port and replaces hand-driven `sel_in` stimulus in the integrated design.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles a single grant is held. Legal range 1..15. The hold counter is 4 bits.
- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `req_in`  input  4  request per requester; bit i means requester i wants the mux.
- `data_in`  input  4  mux data; bit i is requester i's data bit.
- `grant_out`  output  4  one-hot grant, or all zeros when idle; registered.
- `sel_out`  output  2  binary index of the granted requester; drives the mux `sel_in`; registered.
- `y_out`  output  1  registered mux output, equal to `data_in[sel_out]` sampled while granted.
- `valid_out`  output  1  high when `y_out` holds data sampled under an active grant.
- `busy_out`  output  1  high while any grant is active; equals `|grant_out`.

## Operation
- Clock and reset: one clock, `clk_in`. Reset `rst_in` is synchronous and active-high.
- State: FSM with two states, IDLE and GRANT. It also holds a 2-bit round-robin pointer `ptr` and a 4-bit hold counter `cnt`.
- Priority search: start at index `ptr` and step `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first set bit of `req_in` wins.
- IDLE:
  - If `req_in == 0`, stay in IDLE. Outputs keep their idle values.
  - If `req_in != 0`, arbitrate. On the next edge, go to GRANT and set `grant_out = 1<<w`, `sel_out = w`, `cnt = 1`.
- GRANT, with current grantee g:
  - Hold when `req_in[g] == 1` and `cnt < HOLD_MAX`. Grant is unchanged and `cnt` increments.
  - Release when `req_in[g] == 0` or `cnt == HOLD_MAX`.
  - On release, `ptr` becomes `g+1` mod 4, and arbitration uses that new pointer in the same cycle.
  - After release with any other request pending, the next grant appears on the next edge with `cnt = 1`. There is no idle bubble.
  - After release with no request pending (g's own request is eligible again, at lowest priority), go to IDLE and clear `grant_out`.
- Data path:
  - Every edge: `y_out <= data_in[sel_out]` and `valid_out <= busy_out`.
  - When idle, `y_out` holds its last value and `valid_out` is 0.
- Requests are level-sensitive. A requester can lose the mux on a `HOLD_MAX` release while still requesting; it is re-served in round-robin order.
- `HOLD_MAX = 1` makes every grant exactly one cycle. Under full load the grants then rotate 0,1,2,3.

## Timing
- Reset:
  - `grant_out = 0`, `sel_out = 0`, `y_out = 0`, `valid_out = 0`, `busy_out = 0`.
  - `ptr = 0` (requester 0 has highest priority), `cnt = 0`, state IDLE.
- Reset mid-grant: the grant clears on that same edge and no data from that cycle is flagged valid. After reset is released, arbitration restarts from `ptr = 0`.
- Latency:
  - `req_in` sampled high at edge N gives `grant_out`/`sel_out` valid after N.
  - `y_out`/`valid_out` for that grant appear after edge N+1.
- Grant duration is `min(request length, HOLD_MAX)` cycles.
- Re-request after drop: when the grantee drops `req_in[g]` and re-raises it on the next cycle, it wins only if no higher-priority request is pending at that time.
- Hand-off: the last cycle of `valid_out` for grantee A is followed directly by the first `valid_out` for grantee B, with no gap.
- Only `grant_out`, `sel_out`, `y_out`, `valid_out` and `busy_out` are outputs. None are combinational from `req_in` or `data_in`.

## Test plan
- Reset then single request: hold `req_in = 4'b0100` with `data_in = 4'b0100`. Required:
  - after edge 1: `grant_out = 4'b0100` and `sel_out = 2`;
  - after edge 2: `y_out = 1` and `valid_out = 1`;
  - after 4 cycles of grant: a release, then the same grant again on the next edge with `cnt = 1`.
- Full load with `HOLD_MAX = 4`: `req_in = 4'b1111` held. Required: grants 0,1,2,3,0…, each exactly 4 cycles, with `busy_out` never low.
- Early drop: requester 1 is granted and drops `req_in[1]` after 2 cycles while `req_in = 4'b1001`. Required: next grant goes to 3 (ptr = 2 search order 2,3,0,1), with no idle cycle.
- Data tracking: requester 3 is granted and `data_in` toggles between 4'b1000 and 4'b0000 every cycle. Required: `y_out` follows `data_in[3]` delayed by one cycle, with `valid_out = 1` throughout.
- Reset mid-grant: assert `rst_in` during cycle 2 of a grant to requester 2. Required: all outputs are 0 after that edge. After release with `req_in = 4'b0110`, the grant goes to 1.
- Idle: `req_in = 0` for 10 cycles after reset. Required: `grant_out = 0`, `valid_out = 0`, `busy_out = 0`, and `y_out` unchanged.
